// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end between the CPU MEM stage and a word-wide data memory.
// It takes one byte, half or word request at a time, checks alignment, drives
// the memory strobes with store data replicated across the lanes, waits for
// DataReady with a timeout, and sign- or zero-extends the load result.
// Little endian: byte offset n maps to lane n (lane 0 = bits 7:0, BE[0]).
//
// Parameters
//   TIMEOUT  max ACCESS cycles spent waiting for DataReady before abort (>=1)
//   CNT_W    width of the timeout counter (must hold TIMEOUT)
//
// Ports
//   Clk, Reset        clock; asynchronous active-high reset
//   Req               request strobe, sampled only in IDLE
//   Wr                1 = store, 0 = load
//   Size              00 byte, 01 half, 10 word, 11 reserved (error)
//   Unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   AddrIn, WData     byte address and right-justified store data
//   RData             load result, held until the next load completes
//   Busy              high from accepted Req until the Done cycle
//   Done, AddrErr     one-cycle completion / error pulses
//   CS, RW, BE, Addr  memory strobes, lane enables, word address
//   DataIn            memory write data, lanes replicated
//   DataOut, DataReady memory read data and completion
//   MemSign           tied 0; all extension is done here
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] AddrIn,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic        CS,
  output logic        RW,
  output logic [3:0]  BE,
  output logic [31:0] Addr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  input  logic        DataReady,
  output logic        MemSign
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Request fields needed after acceptance; the CPU may change its inputs.
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;

  logic             misaligned;
  logic [3:0]       be_next;
  logic [31:0]      din_next;

  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_val;

  assign MemSign = 1'b0;

  // Request decode: alignment check, lane enables and replicated store data.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b0000;
    din_next   = WData;
    case (Size)
      2'b00: begin
        be_next  = 4'b0001 << AddrIn[1:0];
        din_next = {4{WData[7:0]}};
      end
      2'b01: begin
        misaligned = AddrIn[0];
        be_next    = AddrIn[1] ? 4'b1100 : 4'b0011;
        din_next   = {2{WData[15:0]}};
      end
      2'b10: begin
        misaligned = |AddrIn[1:0];
        be_next    = 4'b1111;
        din_next   = WData;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load extraction from the latched offset/size; DataOut is valid by the
  // posedge that sees DataReady because memory samples on the negedge.
  always_comb begin
    lane_byte = DataOut[{off_q, 3'b000} +: 8];
    lane_half = off_q[1] ? DataOut[31:16] : DataOut[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, lane_byte}
                                : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = uns_q ? {16'h0000, lane_half}
                                : {{16{lane_half[15]}}, lane_half};
      default: load_val = DataOut;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      RData   <= 32'h0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      CS      <= 1'b0;
      RW      <= 1'b0;
      BE      <= 4'b0000;
      Addr    <= 32'h0;
      DataIn  <= 32'h0;
    end else begin
      // Completion flags are single-cycle pulses.
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            Busy   <= 1'b1;
            size_q <= Size;
            uns_q  <= Unsigned;
            off_q  <= AddrIn[1:0];
            if (misaligned) begin
              state <= ERR;
            end else begin
              state  <= ACCESS;
              CS     <= 1'b1;
              RW     <= Wr;
              Addr   <= {AddrIn[31:2], 2'b00};
              BE     <= be_next;
              DataIn <= din_next;
              cnt    <= '0;
            end
          end
        end
        ACCESS: begin
          if (DataReady) begin
            state <= IDLE;
            CS    <= 1'b0;
            BE    <= 4'b0000;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            if (!RW) RData <= load_val;
          end else if (cnt == CNT_LAST) begin
            state <= ERR;
            CS    <= 1'b0;
            BE    <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          state   <= IDLE;
          Done    <= 1'b1;
          AddrErr <= 1'b1;
          Busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with a small behavioural word memory
// that samples CS/RW/BE/Addr/DataIn on the negedge. TIMEOUT is set to 4.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        Wr;
  logic [1:0]  Size;
  logic        uns;
  logic [31:0] AddrIn;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Busy;
  logic        Done;
  logic        AddrErr;
  logic        CS;
  logic        RW;
  logic [3:0]  BE;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DataReady;
  logic        MemSign;

  int n_checks;
  int n_fail;

  // Memory model: 16 words, preloaded through pre_* from the stimulus side.
  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(5)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req       (Req),
    .Wr        (Wr),
    .Size      (Size),
    .Unsigned  (uns),
    .AddrIn    (AddrIn),
    .WData     (WData),
    .RData     (RData),
    .Busy      (Busy),
    .Done      (Done),
    .AddrErr   (AddrErr),
    .CS        (CS),
    .RW        (RW),
    .BE        (BE),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .DataReady (DataReady),
    .MemSign   (MemSign)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (pre_we) mem[pre_idx] = pre_data;
    if (CS) begin
      if (RW) begin
        for (int i = 0; i < 4; i++)
          if (BE[i]) mem[Addr[5:2]][8*i +: 8] = DataIn[8*i +: 8];
      end else begin
        DataOut = mem[Addr[5:2]];
      end
    end
  end

  task automatic poke(input logic [3:0] idx, input logic [31:0] d);
    pre_idx  = idx;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge Clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request for exactly one edge, then scrambles every input so a
  // design that keeps using live inputs after acceptance is caught.
  task automatic start(input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge Clk);
    Req = 1'b1; Wr = wr; Size = sz; uns = u; AddrIn = a; WData = wd;
    @(posedge Clk);
    #1;
    Req = 1'b0; Wr = ~wr; Size = 2'b11; uns = ~u;
    AddrIn = 32'hFFFF_FFFF; WData = 32'h5A5A_5A5A;
  endtask

  task automatic do_load(input string nm, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [3:0] exp_be,
                         input logic [31:0] exp_rd);
    start(1'b0, sz, u, a, 32'h0);
    n_checks++;
    if ({CS, RW, Busy, Done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL %s cs/rw/busy/done: got %b expected 1010", nm, {CS, RW, Busy, Done});
    end
    n_checks++;
    if (BE !== exp_be) begin
      n_fail++;
      $display("FAIL %s be: got %b expected %b", nm, BE, exp_be);
    end
    n_checks++;
    if (Addr !== {a[31:2], 2'b00}) begin
      n_fail++;
      $display("FAIL %s addr: got %h expected %h", nm, Addr, {a[31:2], 2'b00});
    end
    step();
    n_checks++;
    if ({CS, Busy, Done, AddrErr} !== 4'b0010) begin
      n_fail++;
      $display("FAIL %s cs/busy/done/err: got %b expected 0010", nm, {CS, Busy, Done, AddrErr});
    end
    n_checks++;
    if (RData !== exp_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", nm, RData, exp_rd);
    end
  endtask

  task automatic do_store(input string nm, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_din,
                          input logic [31:0] hold_rd);
    start(1'b1, sz, 1'b0, a, wd);
    n_checks++;
    if ({CS, RW, BE} !== {2'b11, exp_be}) begin
      n_fail++;
      $display("FAIL %s cs/rw/be: got %b expected %b", nm, {CS, RW, BE}, {2'b11, exp_be});
    end
    n_checks++;
    if (DataIn !== exp_din) begin
      n_fail++;
      $display("FAIL %s datain: got %h expected %h", nm, DataIn, exp_din);
    end
    n_checks++;
    if (Addr !== {a[31:2], 2'b00}) begin
      n_fail++;
      $display("FAIL %s addr: got %h expected %h", nm, Addr, {a[31:2], 2'b00});
    end
    step();
    n_checks++;
    if ({Done, AddrErr, CS} !== 3'b100 || RData !== hold_rd) begin
      n_fail++;
      $display("FAIL %s done/err/cs rdata: got %b %h expected 100 %h", nm,
               {Done, AddrErr, CS}, RData, hold_rd);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Size = 2'b00; uns = 1'b0;
    AddrIn = 32'h0; WData = 32'h0; DataReady = 1'b1; pre_we = 1'b0;
    pre_idx = 4'h0; pre_data = 32'h0; DataOut = 32'h0;
    #12;
    n_checks++;
    if ({RData, Busy, Done, AddrErr, CS, RW, BE, Addr, DataIn, MemSign} !== 106'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got rdata=%h busy=%b done=%b err=%b cs=%b rw=%b be=%b addr=%h din=%h ms=%b expected all zero",
               RData, Busy, Done, AddrErr, CS, RW, BE, Addr, DataIn, MemSign);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_lw();
    poke(4'd0, 32'h0000_0005);
    do_load("lw0", 2'b10, 1'b0, 32'h0, 4'b1111, 32'h0000_0005);
  endtask

  task automatic test_lb_lbu_lh();
    poke(4'd0, 32'h80FF_1234);
    do_load("lb3",  2'b00, 1'b0, 32'h3, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu3", 2'b00, 1'b1, 32'h3, 4'b1000, 32'h0000_0080);
    do_load("lb1",  2'b00, 1'b0, 32'h1, 4'b0010, 32'h0000_0012);
    do_load("lb2",  2'b00, 1'b0, 32'h2, 4'b0100, 32'hFFFF_FFFF);
    do_load("lh2",  2'b01, 1'b0, 32'h2, 4'b1100, 32'hFFFF_80FF);
    do_load("lhu2", 2'b01, 1'b1, 32'h2, 4'b1100, 32'h0000_80FF);
    do_load("lh0",  2'b01, 1'b0, 32'h0, 4'b0011, 32'h0000_1234);
  endtask

  task automatic test_store();
    poke(4'd1, 32'h1111_1111);
    do_store("sh6", 2'b01, 32'h6, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_1234);
    n_checks++;
    if (mem[1] !== 32'hABCD_1111) begin
      n_fail++;
      $display("FAIL sh6 memory: got %h expected %h", mem[1], 32'hABCD_1111);
    end
    do_store("sb5", 2'b00, 32'h5, 32'h1234_56EE, 4'b0010, 32'hEEEE_EEEE, 32'h0000_1234);
    do_store("sw4", 2'b10, 32'hC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0000_1234);
    do_load("lw4", 2'b10, 1'b0, 32'h4, 4'b1111, 32'hABCD_EE11);
    do_load("lw12", 2'b10, 1'b0, 32'hC, 4'b1111, 32'hCAFE_F00D);
  endtask

  task automatic test_misaligned();
    logic [1:0]  szs [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
    logic [31:0] ads [5] = '{32'h2, 32'h1, 32'h1, 32'h3, 32'h0};
    for (int t = 0; t < 5; t++) begin
      start(1'b0, szs[t], 1'b0, ads[t], 32'h0);
      n_checks++;
      if ({CS, Busy, Done} !== 3'b010) begin
        n_fail++;
        $display("FAIL misalign%0d accept cs/busy/done: got %b expected 010", t, {CS, Busy, Done});
      end
      step();
      n_checks++;
      if ({CS, Busy, Done, AddrErr} !== 4'b0011 || RData !== 32'hCAFE_F00D) begin
        n_fail++;
        $display("FAIL misalign%0d done cs/busy/done/err rdata: got %b %h expected 0011 cafef00d",
                 t, {CS, Busy, Done, AddrErr}, RData);
      end
      step();
      n_checks++;
      if ({CS, Done, AddrErr} !== 3'b000) begin
        n_fail++;
        $display("FAIL misalign%0d pulse cs/done/err: got %b expected 000", t, {CS, Done, AddrErr});
      end
    end
  endtask

  task automatic test_timeout();
    int   cs_cnt;
    int   k_done;
    logic err_at_done;
    logic busy_at_done;
    DataReady = 1'b0;
    cs_cnt = 0; k_done = -1; err_at_done = 1'b0; busy_at_done = 1'b1;
    start(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    if (CS) cs_cnt++;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (CS) cs_cnt++;
      if (Done) begin
        k_done = k; err_at_done = AddrErr; busy_at_done = Busy;
        break;
      end
    end
    n_checks++;
    if (cs_cnt !== 4) begin
      n_fail++;
      $display("FAIL timeout cs cycles: got %0d expected 4", cs_cnt);
    end
    n_checks++;
    if (k_done !== 5) begin
      n_fail++;
      $display("FAIL timeout done cycle: got %0d expected 5", k_done);
    end
    n_checks++;
    if ({err_at_done, busy_at_done} !== 2'b10 || RData !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL timeout err/busy rdata: got %b %h expected 10 cafef00d",
               {err_at_done, busy_at_done}, RData);
    end
    step();
    n_checks++;
    if ({Done, AddrErr, CS} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout pulse done/err/cs: got %b expected 000", {Done, AddrErr, CS});
    end
    DataReady = 1'b1;
  endtask

  task automatic test_ignored_req();
    poke(4'd2, 32'h0000_0042);
    poke(4'd3, 32'h3333_3333);
    DataReady = 1'b0;
    start(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b10; AddrIn = 32'hC; WData = 32'hDEAD_BEEF;
    step();
    step();
    n_checks++;
    if ({CS, RW, Busy} !== 3'b101 || Addr !== 32'h8) begin
      n_fail++;
      $display("FAIL ignored busy-req cs/rw/busy addr: got %b %h expected 101 00000008",
               {CS, RW, Busy}, Addr);
    end
    @(negedge Clk);
    Req = 1'b0;
    DataReady = 1'b1;
    step();
    n_checks++;
    if (Done !== 1'b1 || RData !== 32'h0000_0042) begin
      n_fail++;
      $display("FAIL ignored done rdata: got %b %h expected 1 00000042", Done, RData);
    end
    step();
    n_checks++;
    if ({CS, Busy} !== 2'b00 || mem[3] !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL ignored not-queued cs/busy mem3: got %b %h expected 00 33333333",
               {CS, Busy}, mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    DataReady = 1'b1;
    start(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    step();
    n_checks++;
    if (Done !== 1'b1 || RData !== 32'h80FF_1234) begin
      n_fail++;
      $display("FAIL b2b first done rdata: got %b %h expected 1 80ff1234", Done, RData);
    end
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b0; Size = 2'b00; uns = 1'b1; AddrIn = 32'h1;
    @(posedge Clk);
    #1 Req = 1'b0;
    n_checks++;
    if ({CS, Busy, Done, BE} !== 7'b1100010 || Addr !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b second accept cs/busy/done/be addr: got %b %h expected 1100010 00000000",
               {CS, Busy, Done, BE}, Addr);
    end
    step();
    n_checks++;
    if (Done !== 1'b1 || RData !== 32'h0000_0012) begin
      n_fail++;
      $display("FAIL b2b second done rdata: got %b %h expected 1 00000012", Done, RData);
    end
  endtask

  task automatic test_reset_mid_access();
    DataReady = 1'b0;
    start(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    step();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({CS, Busy, Done} !== 3'b000 || RData !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset cs/busy/done rdata: got %b %h expected 000 00000000",
               {CS, Busy, Done}, RData);
    end
    @(negedge Clk);
    Reset = 1'b0;
    DataReady = 1'b1;
    do_load("after_reset", 2'b10, 1'b0, 32'h8, 4'b1111, 32'h0000_0042);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lw();
    test_lb_lbu_lh();
    test_store();
    test_misaligned();
    test_timeout();
    test_ignored_req();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Run-away guard: the directed sequence needs only a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
